// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a 256 x 32-bit data memory.
// Sub-word stores become read-modify-write; loads are lane-selected and extended.
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [1:0]        r_lane;
  logic [31:0]       r_wdata;
  logic [31:0]       r_merged;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [ADDR_W-3:0] r_mem_addr;

  logic              w_accept;
  logic              w_req_err;
  logic              w_sw;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_merged;

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_valid may stay high while req_ready is low.
  assign w_accept = req_valid & req_ready;
  assign w_sw     = r_we & (r_f3[1:0] == 2'b10);

  always_comb begin
    w_req_err = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: w_req_err = 1'b0;
      3'b100, 3'b101:         w_req_err = req_we;
      default:                w_req_err = 1'b1;
    endcase
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      w_req_err = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
      w_req_err = 1'b1;
  end

  // Lane select and extension of the word currently read from memory.
  always_comb begin
    w_byte   = mem_rdata[{r_lane, 3'b000} +: 8];
    w_half   = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_load   = mem_rdata;
    w_merged = mem_rdata;
    case (r_f3[1:0])
      2'b00: begin
        w_load = {{24{~r_f3[2] & w_byte[7]}}, w_byte};
        w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
      end
      2'b01: begin
        w_load = {{16{~r_f3[2] & w_half[15]}}, w_half};
        w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
      end
      default: begin
        w_load   = mem_rdata;
        w_merged = mem_rdata;
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = w_req_err ? S_RESP : S_ACCESS;
      S_ACCESS: w_next = (r_we && !w_sw) ? S_WRITE : S_RESP;
      S_WRITE:  w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_f3       <= 3'b000;
      r_lane     <= 2'b00;
      r_wdata    <= 32'h0;
      r_merged   <= 32'h0;
      r_rdata    <= 32'h0;
      r_err      <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_accept) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_lane  <= req_addr[1:0];
        r_wdata <= req_wdata;
        r_err   <= w_req_err;
        r_rdata <= 32'h0;
        if (!w_req_err) r_mem_addr <= req_addr[ADDR_W-1:2];
      end
      if (r_state == S_ACCESS) begin
        if (!r_we) r_rdata <= w_load;
        r_merged <= w_merged;
      end
    end
  end

  // Write enable is decoded from registered state only, so an async reset
  // removes it before the falling edge that would commit the write.
  assign mem_we     = (r_state == S_WRITE) | ((r_state == S_ACCESS) & w_sw);
  assign mem_wdata  = (r_state == S_WRITE) ? r_merged :
                      ((r_state == S_ACCESS) & w_sw) ? r_wdata : 32'h0;
  assign mem_addr   = r_mem_addr;
  assign req_ready  = (r_state == S_IDLE) & rst_n;
  assign resp_valid = (r_state == S_RESP);
  assign resp_err   = r_err;
  assign resp_rdata = r_rdata;
  assign dbg_state  = r_state;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Byte-addressed load/store front end for the CPU's 1 KB word-wide data memory (256 × 32-bit, write on falling clock edge, asynchronous read, no byte enables). Sits between the execute stage and the data memory. Accepts one RISC-V load or store per request and converts byte and halfword stores into read-modify-write sequences. Sign- or zero-extends load data and flags misaligned or illegal accesses.

## Interface
Parameters:
- ADDR_W, 10, byte-address width; word address is addr[ADDR_W-1:2] (8 bits).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request; high only in IDLE with rst_n high.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V size code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data; low byte/half used for sb/sh.
- resp_valid  output  1  one-cycle response pulse.
- resp_err  output  1  misaligned or illegal request; valid with resp_valid.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- mem_we  output  1  memory write enable; registered state only, stable across the falling edge.
- mem_addr  output  8  memory word address.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data, combinationally valid for mem_addr within the same cycle.

## Operation
- FSM states: IDLE, ACCESS, WRITE, RESP.
- IDLE: a request is accepted on a rising edge with req_valid & req_ready. The edge latches we, funct3, addr and wdata.
- Error check at accept:
  - Illegal funct3 (011, 110, 111, or 1xx with we=1) is an error.
  - addr[0]=1 for h/hu/sh is an error.
  - addr[1:0]≠0 for w/sw is an error.
  - On error: go to RESP with err=1; no memory access.
- Otherwise go to ACCESS with mem_addr = addr[9:2].
- ACCESS behaviour by request type:
  - Load: capture mem_rdata and select the lane by addr[1:0]. lb/lh sign-extend; lbu/lhu zero-extend. Next state RESP.
  - sw: mem_we=1, mem_wdata=wdata; the write happens at this cycle's falling edge. Next state RESP.
  - sb/sh: capture mem_rdata and merge wdata[7:0] or wdata[15:0] into the lane selected by addr[1:0]. Next state WRITE.
- WRITE: mem_we=1, mem_wdata=merged word, mem_addr unchanged. Next state RESP.
- RESP: resp_valid=1 for exactly one cycle. resp_rdata holds load data, else 0; resp_err as computed. Next state IDLE.
- mem_we is 0 in IDLE, ACCESS-load, ACCESS-sub-word-store and RESP.
- mem_addr holds its last value outside ACCESS/WRITE.
- Lane select: byte n = bits [8n+7:8n]; halfword at addr[1]=1 = bits [31:16].

## Timing
- Reset (rst_n low, asynchronous): state IDLE, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0. Requests presented during reset are ignored.
- Latency is counted from the accept edge (cycle 0) to the cycle in which resp_valid is high:
  - load / sw: 2 cycles.
  - sb/sh: 3 cycles.
  - error: 1 cycle.
- req_ready returns high the cycle after RESP, so the minimum request spacing is 3 / 4 / 2 cycles respectively.
- Request inputs are don't-care outside the accept edge; internal latches are used throughout.
- Reset asserted during ACCESS or WRITE before the falling edge: mem_we drops immediately and no memory write occurs. The operation is discarded with no response.
- Addresses wrap within 1 KB; address bits above ADDR_W do not exist.

## Test plan
- sw addr 0x010 data 0xDEADBEEF, then lw 0x010 → resp_rdata=0xDEADBEEF, err=0; resp_valid 2 cycles after each accept.
- Memory word 0x14 = 0x11223344; sb addr 0x015 data 0xAA → word becomes 0x1122AA44; resp_valid at cycle 3; mem_we high exactly one cycle, in WRITE.
- Word 0x20 = 0x80FF7F01: lb 0x022 → 0xFFFFFFFF; lbu 0x023 → 0x00000080; lh 0x022 → 0xFFFF80FF; lhu 0x020 → 0x00007F01.
- Misaligned and illegal requests: lw 0x006, sh 0x003, funct3=011 → resp_err=1, resp_rdata=0 at cycle 1; mem_we never asserted; the target words are unchanged.
- Reset sequencing: pulse rst_n low while in WRITE of an sh → mem_we falls asynchronously, the word is unchanged, no resp_valid, req_ready=0 during reset and 1 the first cycle after release.
- Back-to-back: hold req_valid high with five mixed requests → each accepted only when req_ready=1, one resp_valid per request, in order.
